// File: rtl/map_tick_generator.sv
// Map-scroll tick generator: one shared elapsed counter compared against a live,
// level-dependent period, plus a slow base-level ramp that raises difficulty over time.
module map_tick_generator #(
  parameter int BASE_LEVELS   = 4,
  parameter int PLAYER_LEVELS = 4,
  parameter int VEL_W         = 2,
  parameter int LEVEL_W       = 3,
  parameter int PERIOD_W      = 16,
  parameter int PERIOD_0      = 800,
  parameter int PERIOD_STEP   = 100,
  parameter int PERIOD_MIN    = 200,
  parameter int RAMP_CYCLES   = 30000,
  parameter int RAMP_W        = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               count_map,
  input  logic               ramp_en,
  input  logic [VEL_W-1:0]   velocity,
  output logic               move_map,
  output logic [LEVEL_W-1:0] level,
  output logic [LEVEL_W-1:0] base_level,
  output logic               base_max
);

  localparam int                 VEL_MAX   = PLAYER_LEVELS - 1;
  localparam logic [LEVEL_W-1:0] BASE_TOP  = LEVEL_W'(BASE_LEVELS - 1);
  localparam logic [RAMP_W-1:0]  RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);

  logic [PERIOD_W-1:0] elapsed_q, elapsed_d;
  logic [RAMP_W-1:0]   ramp_q, ramp_d;
  logic [LEVEL_W-1:0]  base_q, base_d;
  logic                move_q, move_d;

  logic [VEL_W-1:0]    vel_clamped;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W:0]   elapsed_inc;
  logic                wrap;

  // Signed int arithmetic so a large level can never underflow below the floor.
  function automatic logic [PERIOD_W-1:0] period_of(input logic [LEVEL_W-1:0] lvl);
    int p;
    p = PERIOD_0 - int'(lvl) * PERIOD_STEP;
    if (p < PERIOD_MIN) p = PERIOD_MIN;
    return PERIOD_W'(p);
  endfunction

  always_comb begin
    vel_clamped = velocity;
    if (int'(velocity) > VEL_MAX) vel_clamped = VEL_W'(VEL_MAX);
  end

  assign level       = base_q + LEVEL_W'(vel_clamped);
  assign period      = period_of(level);
  assign elapsed_inc = {1'b0, elapsed_q} + {{PERIOD_W{1'b0}}, 1'b1};
  // >= rather than == so a level rise past the current elapsed count fires at once.
  assign wrap        = (elapsed_inc >= {1'b0, period});

  always_comb begin
    elapsed_d = elapsed_q;
    ramp_d    = ramp_q;
    base_d    = base_q;
    move_d    = 1'b0;
    if (clear) begin
      elapsed_d = '0;
      ramp_d    = '0;
      base_d    = '0;
    end else if (count_map) begin
      if (wrap) begin
        elapsed_d = '0;
        move_d    = 1'b1;
      end else begin
        elapsed_d = elapsed_inc[PERIOD_W-1:0];
      end
      if (ramp_en) begin
        if (base_q < BASE_TOP) begin
          if (ramp_q == RAMP_LAST) begin
            ramp_d = '0;
            base_d = base_q + LEVEL_W'(1);
          end else begin
            ramp_d = ramp_q + RAMP_W'(1);
          end
        end else begin
          ramp_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      elapsed_q <= '0;
      ramp_q    <= '0;
      base_q    <= '0;
      move_q    <= 1'b0;
    end else begin
      elapsed_q <= elapsed_d;
      ramp_q    <= ramp_d;
      base_q    <= base_d;
      move_q    <= move_d;
    end
  end

  assign move_map   = move_q;
  assign base_level = base_q;
  assign base_max   = (base_q == BASE_TOP);

endmodule

// File: tb/tb_map_tick_generator.sv
// Directed bench for map_tick_generator: a default instance for period/velocity/pause/clear
// behaviour and a fast-ramp, steep-step, clamped-velocity instance for ramp and floor behaviour.
module tb_map_tick_generator;

  logic       clock;
  logic       reset;
  logic       clr, cm, ramp;
  logic [1:0] vel;
  logic       mm, bmax;
  logic [2:0] level, base;
  logic       clr2, cm2, ramp2;
  logic [1:0] vel2;
  logic       mm2, bmax2;
  logic [2:0] level2, base2;

  int checks = 0;
  int errors = 0;
  int pq[$];
  bit dbl;

  map_tick_generator dut (
    .clock(clock), .reset(reset), .clear(clr), .count_map(cm), .ramp_en(ramp),
    .velocity(vel), .move_map(mm), .level(level), .base_level(base), .base_max(bmax)
  );

  map_tick_generator #(
    .PLAYER_LEVELS(3), .PERIOD_STEP(200), .RAMP_CYCLES(50)
  ) dut2 (
    .clock(clock), .reset(reset), .clear(clr2), .count_map(cm2), .ramp_en(ramp2),
    .velocity(vel2), .move_map(mm2), .level(level2), .base_level(base2), .base_max(bmax2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n edges, recording the 1-based edge index after which move_map was high.
  task automatic run(input bit sel, input int n);
    logic cur, prev;
    pq.delete();
    dbl  = 1'b0;
    prev = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clock);
      #1;
      cur = sel ? mm2 : mm;
      if (cur) pq.push_back(k);
      if (cur && prev) dbl = 1'b1;
      prev = cur;
    end
  endtask

  task automatic pulses(input string tag, input int n, input int first, input int last);
    int f, l;
    f = (pq.size() > 0) ? pq[0] : -1;
    l = (pq.size() > 0) ? pq[pq.size()-1] : -1;
    chk({tag, "_count"}, pq.size(), n);
    chk({tag, "_first"}, f, first);
    chk({tag, "_last"}, l, last);
  endtask

  initial begin
    reset = 1'b0;
    clr = 1'b0; cm = 1'b0; ramp = 1'b0; vel = 2'd2;
    clr2 = 1'b0; cm2 = 1'b0; ramp2 = 1'b0; vel2 = 2'd3;
    #2;
    chk("rst_move", int'(mm), 0);
    chk("rst_base", int'(base), 0);
    chk("rst_bmax", int'(bmax), 0);
    chk("rst_level", int'(level), 2);
    chk("rst_level_clamp", int'(level2), 2);
    #20;
    reset = 1'b1;
    vel   = 2'd0;

    // Clamped velocity: level 2, period 800-400 = 400
    cm2 = 1'b1;
    run(1'b1, 800);
    pulses("clamp", 2, 400, 800);

    vel2  = 2'd0;
    ramp2 = 1'b1;
    run(1'b1, 49);
    chk("ramp49_base", int'(base2), 0);
    run(1'b1, 1);
    chk("ramp50_base", int'(base2), 1);
    run(1'b1, 50);
    chk("ramp100_base", int'(base2), 2);
    chk("ramp100_bmax", int'(bmax2), 0);
    run(1'b1, 50);
    chk("ramp150_base", int'(base2), 3);
    chk("ramp150_bmax", int'(bmax2), 1);
    // e=150 at level 3 (period 200): next pulse 50 edges on
    run(1'b1, 100);
    chk("ramp_hold_base", int'(base2), 3);
    pulses("lvl3", 1, 50, 50);

    vel2 = 2'd3;
    #1;
    chk("floor_level", int'(level2), 5);
    // e=50, floored period 200
    run(1'b1, 400);
    pulses("floor", 2, 150, 350);
    cm2 = 1'b0;

    cm = 1'b1;
    run(1'b0, 2400);
    pulses("base", 3, 800, 2400);
    chk("base_mid", (pq.size() > 1) ? pq[1] : -1, 1600);
    chk("base_double", int'(dbl), 0);
    chk("base_level_out", int'(level), 0);

    vel = 2'd3;
    #1;
    chk("v3_level", int'(level), 3);
    run(1'b0, 1000);
    pulses("v3", 2, 500, 1000);

    vel = 2'd0;
    run(1'b0, 650);
    pulses("miss_pre", 0, -1, -1);
    vel = 2'd3;
    run(1'b0, 1);
    pulses("miss", 1, 1, 1);
    run(1'b0, 500);
    pulses("miss_post", 1, 500, 500);

    run(1'b0, 300);
    pulses("rev_pre", 0, -1, -1);
    vel = 2'd0;
    run(1'b0, 500);
    pulses("rev", 1, 500, 500);

    run(1'b0, 400);
    pulses("pause_pre", 0, -1, -1);
    cm = 1'b0;
    run(1'b0, 100);
    pulses("pause", 0, -1, -1);
    cm = 1'b1;
    run(1'b0, 400);
    pulses("resume", 1, 400, 400);

    run(1'b0, 500);
    pulses("clr_pre", 0, -1, -1);
    clr = 1'b1;
    run(1'b0, 1);
    pulses("clr", 0, -1, -1);
    chk("clr_base", int'(base), 0);
    clr = 1'b0;
    run(1'b0, 800);
    pulses("post_clr", 1, 800, 800);
    chk("pre_arst_move", int'(mm), 1);

    // Asynchronous reset between edges
    #2;
    reset = 1'b0;
    #1;
    chk("arst_move", int'(mm), 0);
    chk("arst_base2", int'(base2), 0);
    chk("arst_bmax2", int'(bmax2), 0);
    chk("arst_level2", int'(level2), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/map_tick_generator.md
# map_tick_generator

Parametrised map-scroll tick generator for the delivery game. It emits a one-cycle `move_map` pulse each time the current scroll period elapses. The period comes from a difficulty level: an internally ramped base level plus the player velocity. A single shared elapsed counter is compared against the live period, so a velocity change can never skip or lose a move. It sits between the game FSM (`count_map`, `velocity`) and the map shifter, and exports `level` for the velocimeter PWM.

## Interface
- `BASE_LEVELS`, 4: number of base levels (0..BASE_LEVELS-1).
- `PLAYER_LEVELS`, 4: number of player velocity levels (0..PLAYER_LEVELS-1).
- `VEL_W`, 2: width of `velocity`.
- `LEVEL_W`, 3: width of `level` and `base_level`; must hold BASE_LEVELS+PLAYER_LEVELS-2.
- `PERIOD_W`, 16: width of the elapsed and period arithmetic.
- `PERIOD_0`, 800: period in counted cycles at level 0 (0.8 s at 1 kHz).
- `PERIOD_STEP`, 100: period reduction per level.
- `PERIOD_MIN`, 200: period floor.
- `RAMP_CYCLES`, 30000: counted cycles per base-level increment.
- `RAMP_W`, 16: ramp counter width.

Ports:
- `clock`  in  1  single clock (1 kHz game tick).
- `reset`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous, active-high game restart.
- `count_map`  in  1  count enable (game running).
- `ramp_en`  in  1  enables base-level ramp.
- `velocity`  in  VEL_W  player velocity level.
- `move_map`  out  1  registered one-cycle scroll pulse.
- `level`  out  LEVEL_W  effective level (combinational from `base_level` and `velocity`).
- `base_level`  out  LEVEL_W  registered base level.
- `base_max`  out  1  high while `base_level` = BASE_LEVELS-1.

## Operation
- v = min(`velocity`, PLAYER_LEVELS-1).
- `level` = `base_level` + v. This never exceeds BASE_LEVELS+PLAYER_LEVELS-2.
- P(L) = max(PERIOD_0 - L·PERIOD_STEP, PERIOD_MIN). Compute in signed or guarded arithmetic so that no underflow occurs. P ≥ 1 is required.
- Elapsed counter e, PERIOD_W bits. On each edge with `count_map`=1:
  - If e+1 ≥ P(`level`): e ← 0 and `move_map` ← 1.
  - Otherwise: e ← e+1 and `move_map` ← 0.
- The ≥ compare is mandatory. If the level rises mid-period with e already past the new period, the next counted edge fires.
- When the level drops, e keeps its value and the pulse occurs when e+1 reaches the longer period.
- `count_map`=0: e, ramp counter r and `base_level` hold; `move_map` ← 0.
- Ramp: on a counted edge with `ramp_en`=1 and `base_level` < BASE_LEVELS-1:
  - If r = RAMP_CYCLES-1: r ← 0 and `base_level` ← `base_level`+1.
  - Otherwise: r ← r+1.
- Ramp at max level: r ← 0 and `base_level` saturates.
- `ramp_en`=0: r and `base_level` hold.
- Simultaneous period wrap and base increment on one edge: the compare uses the pre-edge `base_level`. The new level applies from the next edge.
- `clear`=1: e, r, `base_level` ← 0 and `move_map` ← 0. `clear` overrides `count_map`.
- Priority: `reset` > `clear` > `count_map`.

## Timing
- Reset (`reset`=0, asynchronous) takes effect immediately: `move_map`=0, `base_level`=0, e=0, r=0.
- After reset: `base_max`=0 (1 if BASE_LEVELS=1), `level`=v.
- Release from reset is synchronous to the next rising edge.
- With a constant level, `move_map` pulses exactly every P counted cycles. The first pulse is high in the cycle after the P-th counted edge following reset, clear or start.
- `move_map` is never high for two consecutive cycles unless P=1.
- Latency from a `velocity` change to its use in the compare: zero cycles (sampled at the next edge).
- `base_max` is combinational from `base_level`.

## Test plan
- Reset, `count_map`=1, `velocity`=0, `ramp_en`=0 → `move_map` pulses after counted edges 800, 1600, 2400; each pulse is 1 cycle wide; `level`=0.
- `velocity`=3 constant → pulse every 500 counted cycles; `level`=3. `velocity`=3 with PLAYER_LEVELS=3 → clamps to v=2, period 600.
- Missed-move regression: 650 counted edges at `velocity`=0, then `velocity`=3 → pulse on the very next counted edge (e=650 ≥ 500), then every 500. Reverse case: at e=300 drop from 3 to 0 → pulse at e reaching 800, with no pulse at 500.
- Pause: deassert `count_map` for 100 cycles at e=400 (`velocity`=0) → first pulse 100 cycles later than 800; `move_map` stays 0 while paused.
- Ramp with RAMP_CYCLES=50 and `ramp_en`=1:
  - `base_level` steps 0→1→2→3 at counted edges 50, 100, 150; `base_max`=1 from edge 150 and `base_level` holds.
  - With `velocity`=3 → `level`=6, period 200.
  - With PERIOD_STEP=200 → period floors at 200.
- Mid-period `clear` at e=500 → `move_map` 0, `base_level` 0, next pulse 800 edges later. Asynchronous `reset` low between edges → outputs clear immediately, before the next edge.
